// File: rtl/temp_sampler_if.sv
// Sample handshake between a temperature source and temp_sampler.
// A transfer occurs on a rising edge where isample_valid and osample_ready are both high.
interface temp_sampler_if;
    logic [7:0] isample;
    logic       isample_valid;
    logic       osample_ready;

    modport master (output isample, output isample_valid, input  osample_ready);
    modport slave  (input  isample, input  isample_valid, output osample_ready);
endinterface

// File: rtl/temp_sampler.sv
// Averages four temperature samples, converts the mean to BCD one bit per clock,
// and publishes binary, BCD and digit/alarm flags only on a frame tick.
module temp_sampler #(
    parameter logic [7:0] ALARM_C = 8'd60
) (
    input  logic                 iclock,
    input  logic                 ireset,
    temp_sampler_if.slave        smp,
    input  logic                 iframe_tick,
    output logic [7:0]           otemperatura,
    output logic [11:0]          obcd,
    output logic [4:1]           odig_temp,
    output logic                 olost
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CONVERT = 2'd1,
        PENDING = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  acc_q, acc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  avg_q, avg_d;
    logic [7:0]  bin_q, bin_d;
    logic [11:0] bcd_q, bcd_d;
    logic [2:0]  iter_q, iter_d;
    logic [7:0]  temp_q, temp_d;
    logic [11:0] bcd_out_q, bcd_out_d;
    logic [4:1]  dig_q, dig_d;

    logic [9:0]  sum;
    logic [11:0] bcd_adj;
    logic        ready;

    always_ff @(posedge iclock or posedge ireset) begin
        if (ireset) begin
            state_q   <= COLLECT;
            acc_q     <= '0;
            cnt_q     <= '0;
            avg_q     <= '0;
            bin_q     <= '0;
            bcd_q     <= '0;
            iter_q    <= '0;
            temp_q    <= '0;
            bcd_out_q <= '0;
            dig_q     <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            avg_q     <= avg_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            iter_q    <= iter_d;
            temp_q    <= temp_d;
            bcd_out_q <= bcd_out_d;
            dig_q     <= dig_d;
        end
    end

    // Double-dabble step: any BCD digit >= 5 gets +3 before the next left shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < 3; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        avg_d     = avg_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        iter_d    = iter_q;
        temp_d    = temp_q;
        bcd_out_d = bcd_out_q;
        dig_d     = dig_q;

        ready = (state_q == COLLECT);
        sum   = acc_q + {2'b00, smp.isample};

        case (state_q)
            COLLECT: begin
                if (smp.isample_valid) begin
                    if (cnt_q == 2'd3) begin
                        avg_d   = sum[9:2];
                        bin_d   = sum[9:2];
                        bcd_d   = '0;
                        iter_d  = '0;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = CONVERT;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            CONVERT: begin
                bcd_d  = {bcd_adj[10:0], bin_q[7]};
                bin_d  = {bin_q[6:0], 1'b0};
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd7)
                    state_d = PENDING;
            end
            PENDING: begin
                if (iframe_tick) begin
                    temp_d    = avg_q;
                    bcd_out_d = bcd_q;
                    dig_d[1]  = 1'b1;
                    dig_d[2]  = (bcd_q[11:8] != 4'd0) || (bcd_q[7:4] != 4'd0);
                    dig_d[3]  = (bcd_q[11:8] != 4'd0);
                    dig_d[4]  = (avg_q >= ALARM_C);
                    state_d   = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    assign smp.osample_ready = ready;
    assign olost             = smp.isample_valid & ~ready;
    assign otemperatura      = temp_q;
    assign obcd              = bcd_out_q;
    assign odig_temp         = dig_q;

endmodule

// File: tb/tb_temp_sampler.sv
// Directed bench for temp_sampler: table of 4-sample windows with hand-computed
// display values, plus sequences for continuous valid, late tick and reset in PENDING.
module tb_temp_sampler;

    logic        iclock = 1'b0;
    logic        ireset = 1'b0;
    logic        iframe_tick = 1'b0;
    logic [7:0]  otemperatura;
    logic [11:0] obcd;
    logic [4:1]  odig_temp;
    logic        olost;

    temp_sampler_if smp_if ();

    temp_sampler #(.ALARM_C(8'd60)) dut (
        .iclock       (iclock),
        .ireset       (ireset),
        .smp          (smp_if.slave),
        .iframe_tick  (iframe_tick),
        .otemperatura (otemperatura),
        .obcd         (obcd),
        .odig_temp    (odig_temp),
        .olost        (olost)
    );

    always #5 iclock = ~iclock;

    typedef struct {
        logic [3:0][7:0] s;
        logic [7:0]      t;
        logic [11:0]     b;
        logic [3:0]      d;
    } vec_t;

    vec_t vecs[9];

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  disp_t = '0;
    logic [11:0] disp_b = '0;
    logic [3:0]  disp_d = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge iclock);
        #1;
    endtask

    // Offers four samples back-to-back; leaves the DUT in its first CONVERT cycle.
    task automatic send_window(input logic [3:0][7:0] s);
        for (int i = 0; i < 4; i++) begin
            smp_if.isample       = s[i];
            smp_if.isample_valid = 1'b1;
            chk("ready_collect", 32'(smp_if.osample_ready), 32'd1);
            step();
        end
        smp_if.isample_valid = 1'b0;
    endtask

    task automatic check_display(input string tag);
        chk({tag, "_temp"}, 32'(otemperatura), 32'(disp_t));
        chk({tag, "_bcd"},  32'(obcd),         32'(disp_b));
        chk({tag, "_dig"},  32'(odig_temp),    32'(disp_d));
    endtask

    task automatic tick();
        iframe_tick = 1'b1;
        step();
        iframe_tick = 1'b0;
    endtask

    task automatic run_window(input vec_t v, input string tag);
        send_window(v.s);
        repeat (20) step();
        check_display({tag, "_hold"});
        tick();
        disp_t = v.t;
        disp_b = v.b;
        disp_d = v.d;
        check_display(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{s: {8'd23, 8'd22, 8'd21, 8'd20},     t: 8'd21,  b: 12'h021, d: 4'b0011};
        vecs[1] = '{s: {8'd255, 8'd255, 8'd255, 8'd255}, t: 8'd255, b: 12'h255, d: 4'b1111};
        vecs[2] = '{s: {8'd60, 8'd61, 8'd60, 8'd59},     t: 8'd60,  b: 12'h060, d: 4'b1011};
        vecs[3] = '{s: {8'd60, 8'd59, 8'd59, 8'd59},     t: 8'd59,  b: 12'h059, d: 4'b0011};
        vecs[4] = '{s: {8'd5, 8'd5, 8'd5, 8'd5},         t: 8'd5,   b: 12'h005, d: 4'b0001};
        vecs[5] = '{s: {8'd103, 8'd100, 8'd100, 8'd100}, t: 8'd100, b: 12'h100, d: 4'b1111};
        vecs[6] = '{s: {8'd3, 8'd0, 8'd0, 8'd0},         t: 8'd0,   b: 12'h000, d: 4'b0001};
        vecs[7] = '{s: {8'd10, 8'd9, 8'd9, 8'd9},        t: 8'd9,   b: 12'h009, d: 4'b0001};
        vecs[8] = '{s: {8'd10, 8'd10, 8'd10, 8'd10},     t: 8'd10,  b: 12'h010, d: 4'b0011};

        smp_if.isample       = '0;
        smp_if.isample_valid = 1'b0;

        // Reset takes effect with no clock edge.
        #2 ireset = 1'b1;
        #1;
        check_display("reset");
        chk("reset_ready", 32'(smp_if.osample_ready), 32'd1);
        chk("reset_lost",  32'(olost), 32'd0);
        step();
        ireset = 1'b0;

        for (int i = 0; i < 9; i++)
            run_window(vecs[i], $sformatf("vec%0d", i));

        // Continuous valid: 4 accepts, then olost through CONVERT and PENDING.
        smp_if.isample       = 8'd40;
        smp_if.isample_valid = 1'b1;
        for (int k = 0; k < 17; k++) begin
            chk($sformatf("cont_ready%0d", k), 32'(smp_if.osample_ready), (k < 4) ? 32'd1 : 32'd0);
            chk($sformatf("cont_lost%0d", k),  32'(olost),                (k < 4) ? 32'd0 : 32'd1);
            step();
        end
        tick();
        smp_if.isample_valid = 1'b0;
        disp_t = 8'd40; disp_b = 12'h040; disp_d = 4'b0011;
        check_display("cont");

        // Tick in the final CONVERT cycle is ignored.
        send_window({8'd30, 8'd30, 8'd30, 8'd30});
        repeat (7) step();
        tick();
        check_display("late_tick_ignored");
        chk("late_tick_pending", 32'(smp_if.osample_ready), 32'd0);
        repeat (3) step();
        tick();
        disp_t = 8'd30; disp_b = 12'h030; disp_d = 4'b0011;
        check_display("late_tick_next");

        // Reset while PENDING abandons the result and clears the display.
        run_window(vecs[0], "pre_reset");
        send_window({8'd50, 8'd50, 8'd50, 8'd50});
        repeat (12) step();
        chk("pending_before_reset", 32'(smp_if.osample_ready), 32'd0);
        #3 ireset = 1'b1;
        #1;
        disp_t = '0; disp_b = '0; disp_d = '0;
        check_display("mid_reset");
        chk("mid_reset_ready", 32'(smp_if.osample_ready), 32'd1);
        #1 ireset = 1'b0;
        run_window(vecs[4], "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
